uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte-wide transmit queue between the MMIO `TO_HOST` write path and the `UARTTX` serializer. The CPU can push bursts of console bytes without polling `tx_ready` per byte. A small FSM drains the queue into `UARTTX` one byte at a time using its `WE`/`READY` handshake. The block replaces the direct `tx_wdata`/`tx_we` registers in the board top level. MMIO `TO_HOST` reads return `in_ready`.

## Interface
Parameters:
- `DEPTH_LOG`, default 4: queue depth is 2^DEPTH_LOG entries (16).
- `WIDTH`, default 8: data width in bits.

Ports:
- `clk`  in  1  CPU clock; the block has one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `in_we`  in  1  push strobe from MMIO `TO_HOST` write decode; one push per cycle when high.
- `in_wdata`  in  WIDTH  byte to push (`mem_wdata[7:0]`).
- `in_ready`  out  1  high when count < 2^DEPTH_LOG; combinational from the registered count.
- `count`  out  DEPTH_LOG+1  number of queued bytes, 0..2^DEPTH_LOG.
- `overflow`  out  1  sticky flag, set by a push that arrives while the queue is full.
- `clr_overflow`  in  1  clears `overflow`; set has priority if both occur in the same cycle.
- `out_data`  out  WIDTH  byte to `UARTTX` `DATA`; registered and held after each strobe.
- `out_we`  out  1  one-cycle strobe to `UARTTX` `WE`; registered.
- `uart_ready`  in  1  `UARTTX` `READY`.

## Operation
- Storage: 2^DEPTH_LOG x WIDTH register array.
  - Pointers `wr_ptr` and `rd_ptr` are DEPTH_LOG bits wide and wrap modulo depth.
  - `count` is a separate register; full is `count == 2^DEPTH_LOG`, empty is `count == 0`.
- Push: when `in_we` is high and the queue is not full, write `mem[wr_ptr] <= in_wdata` and increment `wr_ptr`.
- Dropped push: when `in_we` is high and the queue is full, the byte is discarded and `overflow` is set. Pointers and count are unchanged.
- Full is judged on the registered count. A push arriving while full is dropped even if a pop happens in the same cycle.
- Count update: `count` increments on an accepted push alone, decrements on a pop alone, and is unchanged when both happen.
- FSM states and transitions:
  - IDLE: if not empty and `uart_ready`, pop: `out_data <= mem[rd_ptr]`, `rd_ptr++`, `out_we <= 1`, go to GUARD. Otherwise stay.
  - GUARD: `out_we <= 0`. Ignore `uart_ready` for this cycle, because `UARTTX` drops READY one cycle after WE. Go to WAIT.
  - WAIT: when `uart_ready` is high, go to IDLE.
- Pop and push ordering: a pop never reads a slot written in the same cycle. Empty is judged on the registered count, so a byte pushed into an empty queue is popped no earlier than the next cycle.
- Data is sent in strict FIFO order.
- Reset (asynchronous, takes effect immediately, including mid-drain):
  - `count`=0, pointers=0, `overflow`=0, `out_we`=0, `out_data`=0, state=IDLE.
  - Queued bytes are lost.
  - `in_ready`=1 while reset is held.

## Timing
- Push at edge t: `count` reflects the byte after edge t; `in_ready` falls in the same cycle that count reaches full.
- Empty queue, `uart_ready` high, push at edge t:
  - the pop happens at edge t+1;
  - `out_we` is high for exactly the cycle t+1..t+2, with `out_data` valid during that cycle.
- Minimum spacing between consecutive `out_we` strobes is 3 edges (IDLE→GUARD→WAIT→IDLE). In practice the spacing is bounded by the `UARTTX` byte time.
- `out_we` is never high on two consecutive cycles.
- `out_we` is never issued while the FSM is outside IDLE.
- Throughput on the push side: one byte per cycle until full.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle → `count`=0, `in_ready`=1, `out_we`=0, `overflow`=0 with no clock edge required.
- Single byte: with `uart_ready`=1, push 0x41 at edge t → `out_we`=1 only in cycle t+1..t+2, `out_data`=0x41, `count` returns to 0 after t+1.
- Fill and overflow:
  - with `uart_ready`=0, push bytes 0x00..0x10 (17 bytes) → `count`=16, `in_ready`=0, `overflow`=1, byte 0x10 dropped;
  - then raise `uart_ready` → exactly 16 strobes carrying 0x00..0x0F in order.
- Handshake: a `UARTTX` model drops READY one cycle after WE and holds it low for 20 cycles; push 3 bytes → 3 strobes, each at least 20 cycles apart, with no duplicate or lost byte.
- Simultaneous push/pop: with `count`=1 and the FSM popping, push 0x55 in the same cycle → `count` stays 1 and 0x55 is sent next.
- Reset mid-drain: queue 8 bytes, assert `rst` after 2 strobes → `out_we` drops immediately, `count`=0, and no further strobes occur after release.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue between MMIO TO_HOST writes and the UARTTX serializer,
// drained one byte at a time through the UARTTX WE/READY handshake.
module uart_tx_fifo #(
  parameter int DEPTH_LOG = 4,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_we,
  input  logic [WIDTH-1:0]     in_wdata,
  output logic                 in_ready,
  output logic [DEPTH_LOG:0]   count,
  output logic                 overflow,
  input  logic                 clr_overflow,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_we,
  input  logic                 uart_ready
);
  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_WAIT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG];
  logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG:0] count_q, count_d;
  logic overflow_q, overflow_d, out_we_q, out_we_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic full, empty, push, pop;
  // count never exceeds 2^DEPTH_LOG, so its MSB alone marks full
  assign full = count_q[DEPTH_LOG];
  assign empty = count_q == '0;
  assign push = in_we && !full;
  assign pop = state_q == S_IDLE && !empty && uart_ready;
  assign in_ready = !full;
  assign count = count_q;
  assign overflow = overflow_q;
  assign out_data = out_data_q;
  assign out_we = out_we_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      out_we_q   <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      out_we_q   <= out_we_d;
      out_data_q <= out_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_wdata;
  end
  // GUARD skips one cycle of READY because UARTTX lowers it a cycle after WE
  always_comb begin
    state_d = state_q == S_IDLE  ? (pop ? S_GUARD : S_IDLE) :
              state_q == S_GUARD ? S_WAIT :
              (uart_ready ? S_IDLE : S_WAIT);
  end
  always_comb begin
    out_we_d   = pop;
    out_data_d = pop ? mem_q[rd_ptr_q] : out_data_q;
    rd_ptr_d   = pop ? rd_ptr_q + DEPTH_LOG'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + DEPTH_LOG'(1) : wr_ptr_q;
    count_d    = (push && !pop) ? count_q + (DEPTH_LOG+1)'(1) :
                 (pop && !push) ? count_q - (DEPTH_LOG+1)'(1) : count_q;
    overflow_d = (in_we && full) ? 1'b1 : clr_overflow ? 1'b0 : overflow_q;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a simple UARTTX READY model.
module tb_uart_tx_fifo;
  logic clk = 1'b0, rst = 1'b1, in_we = 1'b0, clr_overflow = 1'b0;
  logic [7:0] in_wdata = '0, out_data;
  logic [4:0] count;
  logic in_ready, overflow, out_we, uart_ready;
  logic ready_drv = 1'b0, model_en = 1'b0, prev_we = 1'b0;
  int busy = 0, cyc = 0, last_cyc = -1, strobes = 0, checks = 0, failures = 0;
  logic [7:0] sb[$];

  uart_tx_fifo dut (
    .clk(clk), .rst(rst), .in_we(in_we), .in_wdata(in_wdata), .in_ready(in_ready),
    .count(count), .overflow(overflow), .clr_overflow(clr_overflow),
    .out_data(out_data), .out_we(out_we), .uart_ready(uart_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // UARTTX model: READY low for 20 cycles starting the cycle after WE
  assign uart_ready = model_en ? (busy == 0) : ready_drv;
  always @(posedge clk or posedge rst) begin
    if (rst) busy <= 0;
    else if (out_we) busy <= 20;
    else if (busy != 0) busy <= busy - 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_we) begin
      check("we_spacing", int'(prev_we), 0);
      check("strobe_expected", int'(sb.size() != 0), 1);
      if (sb.size() != 0) check("out_data", int'(out_data), int'(sb.pop_front()));
      if (model_en && last_cyc >= 0) check("handshake_gap", int'(cyc - last_cyc >= 20), 1);
      last_cyc = cyc;
      strobes++;
    end
    prev_we = out_we;
  end

  task automatic push(input logic [7:0] b, input bit ok);
    in_we = 1'b1;
    in_wdata = b;
    if (ok) sb.push_back(b);
    @(posedge clk); #1;
    in_we = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input int max, input int settle);
    int n = 0;
    while ((sb.size() != 0 || count != 0) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_in_time", int'(n < max), 1);
    step(settle);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, seen;
    #12 rst = 1'b0;
    step(2);
    // reset check: fill past full, then reset asynchronously mid-cycle
    for (int i = 0; i < 17; i++) push(8'(i), 1'b0);
    check("pre_rst_count", int'(count), 16);
    check("pre_rst_overflow", int'(overflow), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_we", int'(out_we), 0);
    check("rst_overflow", int'(overflow), 0);
    @(posedge clk); #2 rst = 1'b0;
    step(2);
    // single byte with READY high
    ready_drv = 1'b1;
    base = strobes;
    push(8'h41, 1'b1);
    check("single_count_t", int'(count), 1);
    check("single_we_t", int'(out_we), 0);
    step(1);
    check("single_we_t1", int'(out_we), 1);
    check("single_data_t1", int'(out_data), 'h41);
    check("single_count_t1", int'(count), 0);
    step(1);
    check("single_we_t2", int'(out_we), 0);
    step(3);
    check("single_strobes", strobes - base, 1);
    // fill and overflow with READY low
    ready_drv = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    check("fill_count", int'(count), 16);
    check("fill_in_ready", int'(in_ready), 0);
    check("fill_no_overflow", int'(overflow), 0);
    push(8'h10, 1'b0);
    check("ovf_count", int'(count), 16);
    check("ovf_flag", int'(overflow), 1);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    check("ovf_cleared", int'(overflow), 0);
    base = strobes;
    ready_drv = 1'b1;
    wait_drain(200, 5);
    check("fill_strobes", strobes - base, 16);
    check("fill_in_ready_after", int'(in_ready), 1);
    // handshake against the UARTTX READY model
    last_cyc = -1;
    model_en = 1'b1;
    base = strobes;
    for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i), 1'b1);
    wait_drain(300, 30);
    check("hs_strobes", strobes - base, 3);
    model_en = 1'b0;
    // simultaneous push and pop keeps count at 1
    ready_drv = 1'b0;
    push(8'hA0, 1'b1);
    check("sim_count_pre", int'(count), 1);
    ready_drv = 1'b1;
    push(8'h55, 1'b1);
    check("sim_count", int'(count), 1);
    check("sim_we", int'(out_we), 1);
    check("sim_data", int'(out_data), 'hA0);
    wait_drain(50, 5);
    // reset mid-drain after two strobes
    ready_drv = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i), 1'b1);
    ready_drv = 1'b1;
    seen = 0;
    for (int n = 0; n < 40 && seen < 2; n++) begin
      @(posedge clk); #1;
      if (out_we) seen++;
    end
    check("mid_two_strobes", seen, 2);
    #1 rst = 1'b1;
    #1;
    check("mid_we_drop", int'(out_we), 0);
    check("mid_count", int'(count), 0);
    sb.delete();
    @(posedge clk); #2 rst = 1'b0;
    base = strobes;
    step(60);
    check("mid_no_strobes", strobes - base, 0);
    check("mid_count_after", int'(count), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
